// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode bus: fetch-side inputs (stall, flush, instr_in, pc_in)
// and the registered decode-side outputs of the buffer.
interface fetch_decode_buffer_if;
    logic        stall;
    logic        flush;
    logic [15:0] instr_in;
    logic [31:0] pc_in;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        wait_imm;

    modport master (
        output stall, flush, instr_in, pc_in,
        input  instr_out, imm_out, pc_out, valid_out, wait_imm
    );

    modport slave (
        input  stall, flush, instr_in, pc_in,
        output instr_out, imm_out, pc_out, valid_out, wait_imm
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Fetch/decode pipeline register that assembles one- and two-word instructions.
// A word with bit 0 set is held until its immediate arrives on the next accepted cycle.
module fetch_decode_buffer #(
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    fetch_decode_buffer_if.slave       bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] held_word;
    logic [31:0] held_pc;
    logic [15:0] held_word_d;
    logic [31:0] held_pc_d;

    logic [15:0] instr_q;
    logic [15:0] imm_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [15:0] instr_d;
    logic [15:0] imm_d;
    logic [31:0] pc_d;
    logic        valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush beats stall; stall freezes the FSM without consuming instr_in.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else if (!bus.stall) begin
            case (state)
                IDLE:     state_next = bus.instr_in[0] ? WAIT_IMM : IDLE;
                WAIT_IMM: state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        instr_d     = instr_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        held_word_d = held_word;
        held_pc_d   = held_pc;
        if (bus.flush) begin
            instr_d     = NOP_WORD;
            imm_d       = 16'h0000;
            pc_d        = 32'h0000_0000;
            valid_d     = 1'b0;
            held_word_d = 16'h0000;
            held_pc_d   = 32'h0000_0000;
        end else if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (bus.instr_in[0]) begin
                        held_word_d = bus.instr_in;
                        held_pc_d   = bus.pc_in;
                        instr_d     = NOP_WORD;
                        imm_d       = 16'h0000;
                        pc_d        = 32'h0000_0000;
                        valid_d     = 1'b0;
                    end else begin
                        instr_d = bus.instr_in;
                        imm_d   = 16'h0000;
                        pc_d    = bus.pc_in;
                        valid_d = 1'b1;
                    end
                end
                WAIT_IMM: begin
                    // The incoming word is pure data here, so its bit 0 is not looked at.
                    instr_d     = held_word;
                    imm_d       = bus.instr_in;
                    pc_d        = held_pc;
                    valid_d     = 1'b1;
                    held_word_d = 16'h0000;
                    held_pc_d   = 32'h0000_0000;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_word <= 16'h0000;
            held_pc   <= 32'h0000_0000;
            instr_q   <= NOP_WORD;
            imm_q     <= 16'h0000;
            pc_q      <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            held_word <= held_word_d;
            held_pc   <= held_pc_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.instr_out = instr_q;
    assign bus.imm_out   = imm_q;
    assign bus.pc_out    = pc_q;
    assign bus.valid_out = valid_q;
    assign bus.wait_imm  = (state == WAIT_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, async
// reset sequences, and randomized traffic against an instruction-assembly model.
module tb_fetch_decode_buffer;

    localparam logic [15:0] TB_NOP = 16'hE0E0;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    fetch_decode_buffer_if bus ();

    fetch_decode_buffer #(.NOP_WORD(TB_NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic [15:0] instr;
        logic [31:0] pc;
        logic [15:0] exp_instr;
        logic [15:0] exp_imm;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_wait;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic [31:0] pc;
    } fetched_t;

    // Model: accepted words queue up until they form a complete instruction.
    fetched_t    pend_q[$];
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [31:0] m_pc;
    logic        m_valid;

    task automatic modelBubble();
        m_instr = TB_NOP;
        m_imm   = 16'h0000;
        m_pc    = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic modelReset();
        pend_q.delete();
        modelBubble();
    endtask

    task automatic modelStep(input logic s, input logic f, input logic [15:0] w, input logic [31:0] p);
        fetched_t item;
        if (f) begin
            pend_q.delete();
            modelBubble();
        end else if (!s) begin
            item.word = w;
            item.pc   = p;
            pend_q.push_back(item);
            if (pend_q.size() == 1 && pend_q[0].word[0] == 1'b0) begin
                m_instr = pend_q[0].word;
                m_imm   = 16'h0000;
                m_pc    = pend_q[0].pc;
                m_valid = 1'b1;
                pend_q.delete();
            end else if (pend_q.size() == 2) begin
                m_instr = pend_q[0].word;
                m_imm   = pend_q[1].word;
                m_pc    = pend_q[0].pc;
                m_valid = 1'b1;
                pend_q.delete();
            end else begin
                modelBubble();
            end
        end
    endtask

    // Drive at the falling edge, advance through one rising edge, return at the next falling edge.
    task automatic applyStimulus(input logic s, input logic f, input logic [15:0] w, input logic [31:0] p);
        bus.stall    = s;
        bus.flush    = f;
        bus.instr_in = w;
        bus.pc_in    = p;
        modelStep(s, f, w, p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] ei, input logic [15:0] em,
                               input logic [31:0] ep, input logic ev, input logic ew);
        tests++;
        if (bus.instr_out !== ei || bus.imm_out !== em || bus.pc_out !== ep ||
            bus.valid_out !== ev || bus.wait_imm !== ew) begin
            failed++;
            $display("[TB] FAIL %s: got instr=%h imm=%h pc=%h valid=%b wait=%b, expected instr=%h imm=%h pc=%h valid=%b wait=%b",
                     name, bus.instr_out, bus.imm_out, bus.pc_out, bus.valid_out, bus.wait_imm,
                     ei, em, ep, ev, ew);
        end
    endtask

    // Reset pulse between edges: outputs must clear before any clock edge arrives.
    task automatic pulseReset(input string name);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        #2 reset = 1'b1;
        #1 checkOutput(name, TB_NOP, 16'h0000, 32'h0, 1'b0, 1'b0);
        bus.flush = 1'b0;
        #1 reset = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    task automatic addVec(input string n, input logic s, input logic f, input logic [15:0] w,
                          input logic [31:0] p, input logic [15:0] ei, input logic [15:0] em,
                          input logic [31:0] ep, input logic ev, input logic ew);
        vec_t v;
        v.name = n; v.stall = s; v.flush = f; v.instr = w; v.pc = p;
        v.exp_instr = ei; v.exp_imm = em; v.exp_pc = ep; v.exp_valid = ev; v.exp_wait = ew;
        vecs.push_back(v);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.instr_in = 16'h0000;
        bus.pc_in    = 32'h0;
        modelReset();

        addVec("single_word",    0, 0, 16'h1234, 32'h20, 16'h1234, 16'h0000, 32'h20, 1, 0);
        addVec("two_word_first", 0, 0, 16'h5A01, 32'h21, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("two_word_imm",   0, 0, 16'hBEEF, 32'h22, 16'h5A01, 16'hBEEF, 32'h21, 1, 0);
        addVec("stall_first",    0, 0, 16'h0003, 32'h30, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("stall_hold_1",   1, 0, 16'h1111, 32'h31, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("stall_hold_2",   1, 0, 16'h2222, 32'h32, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("stall_hold_3",   1, 0, 16'h3333, 32'h33, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("stall_release",  0, 0, 16'h00FF, 32'h31, 16'h0003, 16'h00FF, 32'h30, 1, 0);
        addVec("flush_first",    0, 0, 16'h0007, 32'h40, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("flush_stall",    1, 1, 16'h9999, 32'h41, TB_NOP,   16'h0000, 32'h00, 0, 0);
        addVec("after_flush",    0, 0, 16'h0002, 32'h42, 16'h0002, 16'h0000, 32'h42, 1, 0);
        addVec("b2b_1",          0, 0, 16'h0010, 32'h60, 16'h0010, 16'h0000, 32'h60, 1, 0);
        addVec("b2b_2a",         0, 0, 16'h0021, 32'h61, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("b2b_2b",         0, 0, 16'hAAAA, 32'h62, 16'h0021, 16'hAAAA, 32'h61, 1, 0);
        addVec("b2b_3",          0, 0, 16'h0030, 32'h63, 16'h0030, 16'h0000, 32'h63, 1, 0);
        addVec("idle_stall",     1, 0, 16'h0005, 32'h70, 16'h0030, 16'h0000, 32'h63, 1, 0);
        addVec("idle_flush",     0, 1, 16'h0005, 32'h71, TB_NOP,   16'h0000, 32'h00, 0, 0);
        addVec("odd_imm_first",  0, 0, 16'h0041, 32'h80, TB_NOP,   16'h0000, 32'h00, 0, 1);
        addVec("odd_imm_data",   0, 0, 16'h0013, 32'h81, 16'h0041, 16'h0013, 32'h80, 1, 0);

        #2 checkOutput("reset_state", TB_NOP, 16'h0000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].instr, vecs[i].pc);
            checkOutput(vecs[i].name, vecs[i].exp_instr, vecs[i].exp_imm, vecs[i].exp_pc,
                        vecs[i].exp_valid, vecs[i].exp_wait);
        end

        $display("[TB] asynchronous reset sequences");
        applyStimulus(0, 0, 16'h0009, 32'h90);
        checkOutput("rst_wait_setup", TB_NOP, 16'h0000, 32'h0, 1'b0, 1'b1);
        pulseReset("async_reset_wait");
        checkOutput("post_reset_hold", TB_NOP, 16'h0000, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 0, 16'h0011, 32'h50);
        checkOutput("post_reset_opcode", TB_NOP, 16'h0000, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 0, 16'h0022, 32'h51);
        checkOutput("post_reset_imm", 16'h0011, 16'h0022, 32'h50, 1'b1, 1'b0);
        applyStimulus(0, 0, 16'h4444, 32'h52);
        checkOutput("rst_valid_setup", 16'h4444, 16'h0000, 32'h52, 1'b1, 1'b0);
        pulseReset("async_reset_valid");

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulseReset("rand_reset");
            end else begin
                logic        s;
                logic        f;
                logic [15:0] w;
                logic [31:0] p;
                s = ($urandom_range(0, 4) == 0);
                f = ($urandom_range(0, 9) == 0);
                w = 16'($urandom);
                p = $urandom;
                applyStimulus(s, f, w, p);
                checkOutput("random", m_instr, m_imm, m_pc, m_valid, pend_q.size() != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter NOP_WORD, default 16'h0000: instruction word driven on instr_out during a bubble.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  1 = hold all state and outputs this cycle.
REQ-005 flush  input  1  1 = discard in-flight content and insert a bubble.
REQ-006 instr_in  input  16  word fetched from instruction memory at pc_in.
REQ-007 pc_in  input  32  program counter value of instr_in, from the program counter register.
REQ-008 instr_out  output  16  registered instruction word to decode.
REQ-009 imm_out  output  16  registered immediate word; 16'h0000 when the instruction has none.
REQ-010 pc_out  output  32  registered PC of the first word of the instruction on instr_out.
REQ-011 valid_out  output  1  1 = instr_out/imm_out/pc_out hold a real instruction; 0 = bubble.
REQ-012 wait_imm  output  1  1 = a first word is held, and the next accepted word is its immediate.

Function
REQ-013 An instruction word with instr_in[0] = 1 SHALL be a two-word instruction; the next sequential word is its 16-bit immediate.
REQ-014 The FSM SHALL have two states: IDLE (no held word) and WAIT_IMM (first word held); wait_imm = 1 only in WAIT_IMM.
REQ-015 IDLE, no stall/flush, instr_in[0] = 0: next edge loads instr_out = instr_in, imm_out = 0, pc_out = pc_in, valid_out = 1; state stays IDLE.
REQ-016 IDLE, no stall/flush, instr_in[0] = 1: next edge stores instr_in and pc_in internally, drives a bubble on the outputs, and enters WAIT_IMM.
REQ-017 WAIT_IMM, no stall/flush: next edge loads instr_out = held word, imm_out = instr_in, pc_out = held PC, valid_out = 1, and returns to IDLE.
REQ-018 In WAIT_IMM, instr_in[0] SHALL be ignored, because the word is data and not an opcode.
REQ-019 A bubble SHALL be instr_out = NOP_WORD, imm_out = 0, pc_out = 0, valid_out = 0.
REQ-020 Latency SHALL be 1 cycle from acceptance of the last word of an instruction to valid_out = 1.
REQ-021 stall = 1 (flush = 0) SHALL hold the state, held word, held PC and all outputs unchanged, and instr_in is not consumed.
REQ-022 flush = 1 SHALL, on the next edge, drive a bubble, clear the held word/PC to 0 and force IDLE, regardless of stall and state.
REQ-023 flush and stall both 1 SHALL resolve as flush; flush has priority.
REQ-024 A flush while in WAIT_IMM SHALL discard the held first word; the following word is decoded as an opcode.
REQ-025 pc_in SHALL pass through unmodified in 32 bits, with no arithmetic performed in this block.
REQ-026 Outputs SHALL come only from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 reset = 1 SHALL immediately, without waiting for a clock edge, force IDLE, held word/PC = 0, instr_out = NOP_WORD, imm_out = 0, pc_out = 0, valid_out = 0, wait_imm = 0.
REQ-028 Reset asserted in WAIT_IMM SHALL drop the held word, and the first edge after deassertion treats instr_in as an opcode.
REQ-029 Reset SHALL override stall and flush.

Verification
REQ-030 Single-word instruction: reset then release, pc_in = 32'h20, instr_in = 16'h1234 -> next edge: instr_out = 16'h1234, imm_out = 0, pc_out = 32'h20, valid_out = 1.
REQ-031 Two-word instruction: pc_in = 32'h21, instr_in = 16'h5A01, then pc_in = 32'h22, instr_in = 16'hBEEF -> edge 1: valid_out = 0, wait_imm = 1; edge 2: instr_out = 16'h5A01, imm_out = 16'hBEEF, pc_out = 32'h21, valid_out = 1, wait_imm = 0.
REQ-032 Stall in WAIT_IMM: after first word 16'h0003 at 32'h30, stall = 1 for 3 cycles with instr_in varying -> outputs and wait_imm constant; then instr_in = 16'h00FF, stall = 0 -> instr_out = 16'h0003, imm_out = 16'h00FF, pc_out = 32'h30.
REQ-033 Flush in WAIT_IMM with stall = 1: held 16'h0007 at 32'h40, flush = stall = 1 -> bubble, wait_imm = 0; next instr_in = 16'h0002 at 32'h42 -> instr_out = 16'h0002, imm_out = 0, valid_out = 1.
REQ-034 Asynchronous reset: in WAIT_IMM, pulse reset between clock edges -> all outputs reach reset values before the next edge; then instr_in = 16'h0011 at 32'h50 -> held, wait_imm = 1 (treated as an opcode).
REQ-035 Back-to-back instructions: 16'h0010, 16'h0021 + 16'hAAAA, 16'h0030 on consecutive cycles -> valid_out pattern 1,0,1,1 with matching pc_out values.
